// File: rtl/serial_fa_ctrl.sv
// serial_fa_ctrl: bit-serial adder sequencer, one full-adder step per clock, LSB first.
// Define SERIAL_FA_SUB_EN to add a sub port that turns the operation into op_a - op_b.
module serial_fa_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_FA_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, STEP, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             s, c0, accept;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

`ifdef SERIAL_FA_SUB_EN
    // Subtraction is a + ~b + 1, so the borrow-free case shows up as cout=1.
    assign b_in = sub ? ~op_b : op_b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = op_b;
    assign c_in = cin;
`endif

    assign s      = a_q[0] ^ b_q[0] ^ carry_q;
    assign c0     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign accept = start && (state_q != STEP);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == STEP) begin
            sum_d   = {s, sum_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = c0;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = FIN;
                cout_d  = c0;
            end
        end else if (accept) begin
            state_d = STEP;
            a_d     = op_a;
            b_d     = b_in;
            carry_d = c_in;
            cnt_d   = '0;
            sum_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == STEP);
    assign done = (state_q == FIN);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_fa_ctrl.sv
// tb_serial_fa_ctrl: scoreboard bench for serial_fa_ctrl; results are popped and compared on each done.
module tb_serial_fa_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0, op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int tests_run = 0;
    int tests_failed = 0;
    logic [W:0] exp_q[$];

    serial_fa_ctrl #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_a(op_a),
        .op_b(op_b),
        .cin(cin),
`ifdef SERIAL_FA_SUB_EN
        .sub(sub),
`endif
        .busy(busy),
        .done(done),
        .sum(sum),
        .cout(cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_done: got sum=%h cout=%b, required no done", sum, cout);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    tests_failed++;
                    $display("FAIL scoreboard: got cout=%b sum=%h, required cout=%b sum=%h",
                             cout, sum, e[W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Issues one accepted start; returns at the negedge of the first STEP cycle with inputs scrambled.
    task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = ci; sub = sb;
        exp_q.push_back(sb ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b} + (W+1)'(ci)));
        @(negedge clk);
        start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL done_timeout: got done=%b after %0d cycles, required done=1", done, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({busy, done, cout, sum} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        go(8'h5A, 8'h3C, 1'b0, 1'b0);
        for (int i = 1; i <= W; i++) begin
            tests_run++;
            if ({busy, done} !== 2'b10) begin
                tests_failed++;
                $display("FAIL basic_busy: cycle k+%0d got busy=%b done=%b, required busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        tests_run++;
        if ({busy, done, cout, sum} !== {3'b010, 8'h96}) begin
            tests_failed++;
            $display("FAIL basic_done: got busy=%b done=%b cout=%b sum=%h, required 0 1 0 96", busy, done, cout, sum);
        end
        @(negedge clk);
        tests_run++;
        if ({busy, done, cout, sum} !== {3'b000, 8'h96}) begin
            tests_failed++;
            $display("FAIL basic_hold: got busy=%b done=%b cout=%b sum=%h, required 0 0 0 96", busy, done, cout, sum);
        end
    endtask

    task automatic test_overflow();
        go(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done();
        tests_run++;
        if ({cout, sum} !== 9'h100) begin
            tests_failed++;
            $display("FAIL overflow_ff_01: got cout=%b sum=%h, required 1 00", cout, sum);
        end
        go(8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done();
        tests_run++;
        if ({cout, sum} !== 9'h1FF) begin
            tests_failed++;
            $display("FAIL overflow_ff_ff_c: got cout=%b sum=%h, required 1 ff", cout, sum);
        end
    endtask

    task automatic test_ignore_start();
        go(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if ({done, cout, sum} !== {2'b10, 8'h46}) begin
            tests_failed++;
            $display("FAIL ignore_start: got done=%b cout=%b sum=%h, required 1 0 46", done, cout, sum);
        end
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, done} !== 2'b00) begin
                tests_failed++;
                $display("FAIL ignore_idle: got busy=%b done=%b, required 0 0", busy, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; op_a = 8'h01; op_b = 8'h01; cin = 1'b0;
        exp_q.push_back(9'h002);
        for (int c = 1; c <= 3 * (W + 1); c++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, done} !== ((c % (W + 1) == 0) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL back_to_back: cycle k+%0d got busy=%b done=%b", c, busy, done);
            end
            if (c % (W + 1) == 0) begin
                if (c < 3 * (W + 1)) exp_q.push_back(9'h002);
                else start = 1'b0;
            end
        end
    endtask

    task automatic test_reset_abort();
        go(8'h80, 8'h80, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        tests_run++;
        if ({busy, done, cout, sum} !== '0) begin
            tests_failed++;
            $display("FAIL abort_async: got busy=%b done=%b cout=%b sum=%h, required all 0", busy, done, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            tests_run++;
            if ({busy, done} !== 2'b00) begin
                tests_failed++;
                $display("FAIL abort_no_done: got busy=%b done=%b, required 0 0", busy, done);
            end
        end
        go(8'h80, 8'h80, 1'b0, 1'b0);
        wait_done();
        tests_run++;
        if ({cout, sum} !== 9'h100) begin
            tests_failed++;
            $display("FAIL abort_recover: got cout=%b sum=%h, required 1 00", cout, sum);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            go(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
            wait_done();
        end
    endtask

`ifdef SERIAL_FA_SUB_EN
    task automatic test_sub();
        go(8'h10, 8'h01, 1'b0, 1'b1);
        wait_done();
        tests_run++;
        if ({cout, sum} !== 9'h10F) begin
            tests_failed++;
            $display("FAIL sub_10_01: got cout=%b sum=%h, required 1 0f", cout, sum);
        end
        go(8'h01, 8'h02, 1'b1, 1'b1);
        wait_done();
        tests_run++;
        if ({cout, sum} !== 9'h0FF) begin
            tests_failed++;
            $display("FAIL sub_01_02: got cout=%b sum=%h, required 0 ff", cout, sum);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
`ifdef SERIAL_FA_SUB_EN
        test_sub();
`endif
        repeat (2) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/serial_fa_ctrl.md
Name:
serial_fa_ctrl

Overview:
- Bit-serial adder controller that time-shares one full-adder cell (a, b, c in; s, c0 out) across a WIDTH-bit addition.
- Latches two operands on a start request, then steps LSB-first through one bit per clock, holding the carry in a flop between steps.
- Reports the completed sum and carry-out with a one-cycle done pulse.
- Sits beside the combinational full-adder cell as its sequencer, for area-constrained arithmetic.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled on the rising edge.
- op_a  input  WIDTH  operand A; sampled when start is accepted.
- op_b  input  WIDTH  operand B; sampled when start is accepted.
- cin  input  1  carry-in; sampled when start is accepted.
- busy  output  1  high while bit steps are in progress.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  result; holds its value after done until the next accepted start.
- cout  output  1  final carry-out; same hold rule as sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Bit counter and carry flop cleared.
  - Operand shift registers cleared.
- States: IDLE, STEP, FIN.
- IDLE:
  - start=1 is accepted: latch op_a, op_b, carry<=cin, counter<=0, sum<=0, go to STEP.
  - start=0: stay in IDLE.
- STEP (busy=1), once per cycle:
  - s = a[0]^b[0]^carry.
  - c0 = majority(a[0], b[0], carry).
  - sum shifts right one place, with s entering at MSB.
  - carry<=c0.
  - a and b shift right one place.
  - counter increments.
  - When counter==WIDTH-1 on this cycle: go to FIN and cout<=c0.
- FIN (busy=0, done=1 for exactly one cycle):
  - With start=1: accept a new operation immediately (same actions as IDLE), enabling back-to-back operation.
  - Otherwise go to IDLE.
- Latency:
  - Start accepted at edge k.
  - STEP occupies cycles k+1 .. k+WIDTH.
  - done is high in cycle k+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1: ignored. Operands and carry are unaffected, and no error is flagged.
- op_a, op_b and cin may change freely after acceptance; they are not observed during STEP.
- sum and cout are stable from the done cycle until the next accepted start, at which point sum clears to 0.
- Reset asserted mid-operation: immediate abort, all outputs return to reset values, and no done pulse is produced.
- Arithmetic is modulo 2^WIDTH; overflow appears only on cout.

Optional Feature:
- SERIAL_FA_SUB_EN
- Defined:
  - Adds port sub (input, 1), sampled with start.
  - When sub=1 at acceptance: b is latched as ~op_b and carry<=1, cin is ignored, and the result is op_a-op_b.
  - cout=1 means no borrow (op_a>=op_b unsigned).
  - When sub=0: behaviour is identical to addition.
- Undefined: the sub port is absent and the block is add-only as above.

Test Plan:
- WIDTH=8, op_a=0x5A, op_b=0x3C, cin=0, start pulsed at edge k -> busy high for cycles k+1..k+8; done high in cycle k+9 only; sum=0x96, cout=0.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1. Then op_a=0xFF, op_b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start 0x12+0x34; assert start again with 0xAA/0x55 at cycle k+3 -> second request ignored; result sum=0x46, cout=0 at k+9; next done occurs only after a new start.
- start held high continuously with 0x01+0x01 -> done pulses every 9 cycles, each with sum=0x02, cout=0; busy=0 only in the done cycles.
- Start 0x80+0x80, drop rst_n at cycle k+4 for 1 cycle -> busy, done, sum and cout go to 0 asynchronously; no done pulse follows; the next start completes normally.
- With SERIAL_FA_SUB_EN defined: 0x10 minus 0x01 (sub=1) -> sum=0x0F, cout=1. 0x01 minus 0x02 -> sum=0xFF, cout=0.
